// File: rtl/skip_feature_buffer_pkg.sv
// Shared types and helpers for the skip feature buffer: FSM state encoding,
// default word width and a constant-evaluable ceil(log2) for pointer sizing.
package skip_feature_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_REPLAY  = 2'd3
  } sfb_state_e;

  localparam int DATA_WIDTH_DEF = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/skip_feature_buffer_if.sv
// Capture stream, replay stream and status of one skip feature buffer.
// skip_valid/rd_ready: a word transfers on every clock edge where both are high;
// once skip_valid rises, skip_out and skip_valid hold until that transfer happens.
// The capture side has no back-pressure: feature_valid alone qualifies feature_in.
interface skip_feature_buffer_if
  import skip_feature_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  wr_start;
  logic [DATA_WIDTH-1:0] feature_in;
  logic                  feature_valid;
  logic                  rd_start;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] skip_out;
  logic                  skip_valid;
  logic                  store_done;
  logic                  replay_done;
  logic                  busy;
  logic                  wr_err;
  sfb_state_e            dbg_state;

  modport master (
    output wr_start, feature_in, feature_valid, rd_start, rd_ready,
    input  skip_out, skip_valid, store_done, replay_done, busy, wr_err, dbg_state
  );

  modport slave (
    input  wr_start, feature_in, feature_valid, rd_start, rd_ready,
    output skip_out, skip_valid, store_done, replay_done, busy, wr_err, dbg_state
  );

endinterface

// File: rtl/skip_feature_buffer_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with enable
// and a registered read output that holds while the enable is low.
module skip_feature_buffer_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/skip_feature_buffer.sv
// Captures one encoder feature map into RAM and replays it, in write order and
// under consumer back-pressure, to the decoder skip input as often as asked.
module skip_feature_buffer
  import skip_feature_buffer_pkg::*;
#(
  parameter int HEIGHT     = 32,
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 512,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  skip_feature_buffer_if.slave bus
);

  localparam int DEPTH      = HEIGHT * WIDTH * CHANNELS;
  localparam int ADDR_WIDTH = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  sfb_state_e            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  all_issued;
  logic                  store_done_q;
  logic                  replay_done_q;
  logic                  busy_q;
  logic                  wr_err_q;

  logic                  wr_en;
  logic                  start_replay;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic [1:0]            occ_after;

  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  dout_vld;
  logic                  dout_last;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH-1:0] q0_data;
  logic [DATA_WIDTH-1:0] q1_data;
  logic                  q0_last;
  logic                  q1_last;

  assign wr_en        = (state == ST_CAPTURE) && bus.feature_valid && !bus.wr_start;
  assign start_replay = (state == ST_FULL) && bus.rd_start && !bus.wr_start;
  assign pop          = (fifo_cnt != 2'd0) && bus.rd_ready;

  // Words already owed to the skid buffer after this cycle; a new read is only
  // issued when its data is guaranteed a slot, so the RAM output never stalls.
  assign occ_after  = fifo_cnt + {1'b0, dout_vld} - {1'b0, pop};
  assign issue      = start_replay ||
                      ((state == ST_REPLAY) && !all_issued && (occ_after < 2'd2));
  // Word 0 is read in the rd_start cycle itself so it reaches skip_out two cycles later.
  assign raddr      = start_replay ? '0 : rd_ptr;
  assign issue_last = (raddr == LAST_ADDR);

  skip_feature_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.feature_in),
    .re    (issue),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      all_issued    <= 1'b0;
      store_done_q  <= 1'b0;
      replay_done_q <= 1'b0;
      busy_q        <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      store_done_q  <= 1'b0;
      replay_done_q <= 1'b0;
      if (bus.wr_start && (state != ST_REPLAY)) wr_err_q <= 1'b0;
      else if (bus.feature_valid && (state != ST_CAPTURE)) wr_err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.wr_start) begin
            state  <= ST_CAPTURE;
            wr_ptr <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (bus.wr_start) begin
            wr_ptr <= '0;
          end else if (bus.feature_valid) begin
            if (wr_ptr == LAST_ADDR) begin
              state        <= ST_FULL;
              store_done_q <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + ADDR_ONE;
            end
          end
        end
        ST_FULL: begin
          if (bus.wr_start) begin
            state  <= ST_CAPTURE;
            wr_ptr <= '0;
            busy_q <= 1'b1;
          end else if (bus.rd_start) begin
            state  <= ST_REPLAY;
            busy_q <= 1'b1;
          end
        end
        ST_REPLAY: begin
          if (pop && q0_last) begin
            state         <= ST_FULL;
            replay_done_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (issue) begin
        all_issued <= issue_last;
        if (!issue_last) rd_ptr <= raddr + ADDR_ONE;
      end
    end
  end

  // Two-entry skid buffer behind the RAM output register; q0 is the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      fifo_cnt  <= 2'd0;
      q0_data   <= '0;
      q1_data   <= '0;
      q0_last   <= 1'b0;
      q1_last   <= 1'b0;
    end else begin
      dout_vld <= issue;
      if (issue) dout_last <= issue_last;
      case ({pop, dout_vld})
        2'b11: begin
          if (fifo_cnt == 2'd2) begin
            q0_data <= q1_data;
            q0_last <= q1_last;
            q1_data <= ram_rdata;
            q1_last <= dout_last;
          end else begin
            q0_data <= ram_rdata;
            q0_last <= dout_last;
          end
        end
        2'b10: begin
          q0_data  <= q1_data;
          q0_last  <= q1_last;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b01: begin
          if (fifo_cnt == 2'd0) begin
            q0_data <= ram_rdata;
            q0_last <= dout_last;
          end else begin
            q1_data <= ram_rdata;
            q1_last <= dout_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.skip_out    = q0_data;
  assign bus.skip_valid  = (fifo_cnt != 2'd0);
  assign bus.store_done  = store_done_q;
  assign bus.replay_done = replay_done_q;
  assign bus.busy        = busy_q;
  assign bus.wr_err      = wr_err_q;
  assign bus.dbg_state   = state;

endmodule
